// File: rtl/dma_fifo_wr_arbiter.sv
// dma_fifo_wr_arbiter: round-robin burst-locked DMA FIFO write-port arbiter; DMA_ARB_STATS_EN adds beat/stall counters
`ifndef DMA_DATA_WIDTH
`define DMA_DATA_WIDTH 32
`endif
module dma_fifo_wr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = `DMA_DATA_WIDTH,
  parameter int LEN_W  = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    clear_i,
  input  logic [NUM_CH-1:0]       req_i,
  input  logic [NUM_CH*LEN_W-1:0] len_i,
  input  logic [NUM_CH-1:0]       valid_i,
  input  logic [NUM_CH*WIDTH-1:0] data_i,
  output logic [NUM_CH-1:0]       gnt_o,
  output logic [NUM_CH-1:0]       ready_o,
  output logic                    busy_o,
  input  logic                    fifo_full_i,
  output logic                    fifo_write_o,
  output logic [WIDTH-1:0]        fifo_data_o
`ifdef DMA_ARB_STATS_EN
  ,
  output logic [NUM_CH*32-1:0]    beat_cnt_o,
  output logic [31:0]             stall_cnt_o
`endif
);
  localparam int SW = $clog2(NUM_CH);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state, state_nx;
  logic [SW-1:0] rr_ptr, sel, pick, k;
  logic [LEN_W-1:0] remaining, len_sel;
  logic found, acc, done;
  // lowest cyclic offset from rr_ptr wins, so scan offsets from high to low
  always_comb begin
    pick = '0;
    k = '0;
    found = |req_i;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      k = SW'((int'(rr_ptr) + i) % NUM_CH);
      pick = req_i[k] ? k : pick;
    end
    len_sel = len_i[int'(pick)*LEN_W +: LEN_W];
  end
  assign busy_o       = (state == BURST);
  assign ready_o      = gnt_o & {NUM_CH{~fifo_full_i & ~clear_i}};
  assign acc          = busy_o & valid_i[sel] & ready_o[sel];
  assign done         = acc & (remaining == LEN_W'(1));
  assign fifo_write_o = acc;
  assign fifo_data_o  = data_i[int'(sel)*WIDTH +: WIDTH];
  always_comb begin
    state_nx = (state == IDLE) ? (found ? BURST : IDLE) : (done ? IDLE : BURST);
  end
  always_ff @(posedge clk) begin
    if (!rstn || clear_i) begin
      state     <= IDLE;
      gnt_o     <= '0;
      rr_ptr    <= '0;
      sel       <= '0;
      remaining <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && found) begin
        sel       <= pick;
        remaining <= (len_sel == '0) ? LEN_W'(1) : len_sel;
        gnt_o     <= NUM_CH'(1) << pick;
      end else if (acc) begin
        remaining <= remaining - LEN_W'(1);
        if (done) begin
          gnt_o  <= '0;
          rr_ptr <= (int'(sel) == NUM_CH - 1) ? '0 : sel + SW'(1);
        end
      end
    end
  end
`ifdef DMA_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rstn || clear_i) begin
      beat_cnt_o  <= '0;
      stall_cnt_o <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (acc && int'(sel) == i && ~&beat_cnt_o[i*32 +: 32])
          beat_cnt_o[i*32 +: 32] <= beat_cnt_o[i*32 +: 32] + 32'd1;
      if (busy_o && fifo_full_i && ~&stall_cnt_o)
        stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dma_fifo_wr_arbiter.sv
// tb_dma_fifo_wr_arbiter: directed scoreboard bench; expected writes and grants are queued by stimulus, popped by a monitor
module tb_dma_fifo_wr_arbiter;
  localparam int N = 4, W = 32, L = 8;
  logic clk = 0, rstn = 0, clear_i = 0, fifo_full_i = 0;
  logic [N-1:0] req_i = '0, valid_i = '0;
  logic [N*L-1:0] len_i = '0;
  logic [N*W-1:0] data_i;
  logic [N-1:0] gnt_o, ready_o, prev_gnt = '0;
  logic busy_o, fifo_write_o;
  logic [W-1:0] fifo_data_o;
`ifdef DMA_ARB_STATS_EN
  logic [N*32-1:0] beat_cnt_o;
  logic [31:0] stall_cnt_o;
`endif
  logic [15:0] idx [N];
  int exp_idx [N] = '{0, 0, 0, 0};
  logic [W-1:0] wq [$];
  logic [N-1:0] gq [$];
  int checks = 0, errors = 0;

  dma_fifo_wr_arbiter #(.NUM_CH(N), .WIDTH(W), .LEN_W(L)) dut (
    .clk(clk), .rstn(rstn), .clear_i(clear_i), .req_i(req_i), .len_i(len_i),
    .valid_i(valid_i), .data_i(data_i), .gnt_o(gnt_o), .ready_o(ready_o),
    .busy_o(busy_o), .fifo_full_i(fifo_full_i), .fifo_write_o(fifo_write_o),
    .fifo_data_o(fifo_data_o)
`ifdef DMA_ARB_STATS_EN
    , .beat_cnt_o(beat_cnt_o), .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  // each channel source emits a tagged incrementing beat stream
  always_comb
    for (int c = 0; c < N; c++) data_i[c*W +: W] = {8'hA0, 8'(c), idx[c]};
  always @(posedge clk)
    for (int c = 0; c < N; c++)
      if (!rstn) idx[c] <= '0;
      else if (ready_o[c] && valid_i[c]) idx[c] <= idx[c] + 16'd1;

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic exp_burst(int c, int n);
    for (int i = 0; i < n; i++) begin
      wq.push_back({8'hA0, 8'(c), 16'(exp_idx[c])});
      exp_idx[c]++;
    end
  endtask
  task automatic set_len(int c, int v);
    len_i[c*L +: L] = L'(v);
  endtask

  always @(negedge clk) begin
    if (fifo_write_o) begin
      if (wq.size() == 0) chk("unexpected_write", fifo_data_o, '0);
      else chk("write_data", fifo_data_o, wq.pop_front());
    end
    if (gnt_o != '0 && prev_gnt == '0) begin
      if (gq.size() == 0) chk("unexpected_grant", gnt_o, '0);
      else chk("grant_order", gnt_o, gq.pop_front());
    end
    if (fifo_write_o && fifo_full_i) chk("write_while_full", 1, 0);
    if ($countones(gnt_o) > 1) chk("gnt_onehot", gnt_o, 0);
    prev_gnt = gnt_o;
  end

  initial begin
    step(2);
    chk("rst_gnt", gnt_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ready", ready_o, 0);
    chk("rst_write", fifo_write_o, 0);
    rstn = 1;
    valid_i = '1;
    // single request, channel 2, three beats
    exp_burst(2, 3);
    gq.push_back(4'b0100);
    req_i = 4'b0100;
    set_len(2, 3);
    step;
    chk("single_gnt", gnt_o, 4'b0100);
    chk("single_busy", busy_o, 1);
    chk("single_ready", ready_o, 4'b0100);
    req_i = '0;
    step(3);
    chk("single_done_busy", busy_o, 0);
    chk("single_done_gnt", gnt_o, 0);
    // rr_ptr now 3: zero length on channel 3, then wrap to channel 0
    gq.push_back(4'b1000);
    gq.push_back(4'b0001);
    exp_burst(3, 1);
    exp_burst(0, 1);
    req_i = 4'b1001;
    set_len(3, 0);
    set_len(0, 1);
    step;
    chk("wrap_gnt3", gnt_o, 4'b1000);
    req_i = 4'b0001;
    step;
    chk("zero_len_one_beat", busy_o, 0);
    step;
    chk("wrap_gnt0", gnt_o, 4'b0001);
    req_i = '0;
    step;
    chk("wrap_done", busy_o, 0);
    clear_i = 1;
    step;
    clear_i = 0;
    // round robin with all requesters, len 2 each
    for (int c = 0; c < N; c++) set_len(c, 2);
    gq.push_back(4'b0001); gq.push_back(4'b0010); gq.push_back(4'b0100);
    gq.push_back(4'b1000); gq.push_back(4'b0001);
    exp_burst(0, 2); exp_burst(1, 2); exp_burst(2, 2); exp_burst(3, 2); exp_burst(0, 2);
    req_i = 4'b1111;
    for (int i = 1; i <= 13; i++) begin
      step;
      if (i == 3) chk("rr_idle_gap", busy_o, 0);
      if (i == 4) chk("rr_second_gnt", gnt_o, 4'b0010);
    end
    req_i = '0;
    step(2);
    chk("rr_done", busy_o, 0);
    clear_i = 1;
    step;
    clear_i = 0;
    // back-pressure on channel 1 during burst cycles 2-4
    gq.push_back(4'b0010);
    exp_burst(1, 4);
    set_len(1, 4);
    req_i = 4'b0010;
    step;
    chk("bp_gnt", gnt_o, 4'b0010);
    req_i = '0;
    step;
    fifo_full_i = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready_stall", ready_o, 0);
      chk("bp_no_write", fifo_write_o, 0);
      chk("bp_gnt_held", gnt_o, 4'b0010);
      step;
    end
    fifo_full_i = 0;
    step(3);
    chk("bp_done", busy_o, 0);
`ifdef DMA_ARB_STATS_EN
    chk("stats_beat_cnt1", beat_cnt_o[32 +: 32], 4);
    chk("stats_stall_cnt", stall_cnt_o, 3);
`endif
    // abort channel 2 after 2 of 5 beats
    gq.push_back(4'b0100);
    exp_burst(2, 2);
    set_len(2, 5);
    req_i = 4'b0100;
    step;
    chk("abort_gnt", gnt_o, 4'b0100);
    req_i = '0;
    step(2);
    clear_i = 1;
    #1;
    chk("abort_no_write", fifo_write_o, 0);
    chk("abort_no_ready", ready_o, 0);
    step;
    clear_i = 0;
    chk("abort_gnt_clr", gnt_o, 0);
    chk("abort_busy_clr", busy_o, 0);
    gq.push_back(4'b0010);
    exp_burst(1, 1);
    set_len(1, 1);
    req_i = 4'b0110;
    step;
    chk("abort_restart_from0", gnt_o, 4'b0010);
    req_i = '0;
    step(3);
    chk("writes_left", wq.size(), 0);
    chk("grants_left", gq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
